// File: rtl/br_pkg.sv
// Shared definitions for the fetch-PC / branch control slice: branch
// opcode encodings, FSM state type, flush-counter width and the
// statistics counter width used when BRANCH_STATS_EN is defined.
package br_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_BNE  = 3'b001,
        OP_BLT  = 3'b010,
        OP_J    = 3'b011,
        OP_JAL  = 3'b100,
        OP_JR   = 3'b101,
        OP_BEX  = 3'b110,
        OP_RSVD = 3'b111
    } br_op_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    localparam int FLUSH_DEPTH_DEF = 2;
    localparam int CNT_W           = 3;
    localparam int STAT_W          = 16;

    // Conditional branches are the only ones the statistics counters see.
    function automatic logic is_cond(input logic [2:0] op);
        return (op == OP_BNE) || (op == OP_BLT) || (op == OP_BEX);
    endfunction

endpackage

// File: rtl/pc_target_adder.sv
// PC-relative target adder: sum = a + b + cin, truncated to PC_W bits
// so the result wraps modulo 2^PC_W.
module pc_target_adder #(
    parameter int PC_W = 12
) (
    input  logic [PC_W-1:0] a,
    input  logic [PC_W-1:0] b,
    input  logic            cin,
    output logic [PC_W-1:0] sum
);

    assign sum = a + b + {{(PC_W-1){1'b0}}, cin};

endmodule

// File: rtl/pc_branch_ctrl.sv
// Fetch PC and branch redirect controller.  A taken branch in execute
// loads the target into the PC and flushes the younger stages for
// FLUSH_DEPTH unstalled cycles.  Optional feature: define
// BRANCH_STATS_EN to add the saturating br_cnt / taken_cnt outputs.
module pc_branch_ctrl
    import br_pkg::*;
#(
    parameter int          PC_W        = 12,
    parameter int unsigned RESET_PC    = 0,
    parameter int          FLUSH_DEPTH = FLUSH_DEPTH_DEF
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            br_valid,
    input  logic [2:0]      br_op,
    input  logic [PC_W-1:0] ex_pc,
    input  logic [31:0]     imm,
    input  logic [31:0]     rs_val,
    input  logic            ne,
    input  logic            lt,
    input  logic            status_nz,
    output logic [PC_W-1:0] pc,
    output logic            flush,
    output logic            link_we,
    output logic [PC_W-1:0] link_pc
`ifdef BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0] br_cnt,
    output logic [STAT_W-1:0] taken_cnt
`endif
);

    state_e           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [PC_W-1:0]  pc_n;
    logic [PC_W-1:0]  rel_target;
    logic [PC_W-1:0]  target;
    logic             taken;
    logic             redirect;
    logic             unused_bits;

    // Only the low PC_W bits of the offset/target operands are meaningful.
    assign unused_bits = ^{imm[31:PC_W], rs_val[31:PC_W]};

    pc_target_adder #(.PC_W(PC_W)) u_adder (
        .a   (ex_pc),
        .b   (imm[PC_W-1:0]),
        .cin (1'b1),
        .sum (rel_target)
    );

    // Branch decision and target selection for the instruction in execute.
    always_comb begin
        taken  = 1'b0;
        target = imm[PC_W-1:0];
        case (br_op)
            OP_BNE: begin taken = ne;        target = rel_target;      end
            OP_BLT: begin taken = lt;        target = rel_target;      end
            OP_J:   begin taken = 1'b1;                                end
            OP_JAL: begin taken = 1'b1;                                end
            OP_JR:  begin taken = 1'b1;      target = rs_val[PC_W-1:0]; end
            OP_BEX: begin taken = status_nz;                           end
            default: begin taken = 1'b0;                               end
        endcase
    end

    assign redirect = br_valid && taken && !stall && (state == ST_RUN);

    // State register: PC, FSM state and flush counter; reset overrides all.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc    <= PC_W'(RESET_PC);
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            pc    <= pc_n;
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic: redirect from RUN, count down in FLUSH, hold on stall.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pc_n    = pc;
        if (!stall) begin
            pc_n = pc + PC_W'(1);
            if (state == ST_RUN) begin
                if (redirect) begin
                    pc_n    = target;
                    state_n = ST_FLUSH;
                    cnt_n   = CNT_W'(FLUSH_DEPTH);
                end
            end else begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n = ST_RUN;
                end
            end
        end
    end

    // Outputs: flush follows the registered state; link write is combinational.
    always_comb begin
        flush   = (state == ST_FLUSH);
        link_we = br_valid && (br_op == OP_JAL) && !stall && (state == ST_RUN);
        link_pc = ex_pc + PC_W'(1);
    end

`ifdef BRANCH_STATS_EN
    logic cond_acc;

    assign cond_acc = br_valid && is_cond(br_op) && !stall && (state == ST_RUN);

    // Saturating counters of accepted and taken conditional branches.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else if (cond_acc) begin
            if (br_cnt != '1) begin
                br_cnt <= br_cnt + STAT_W'(1);
            end
            if (taken && (taken_cnt != '1)) begin
                taken_cnt <= taken_cnt + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Bench for pc_branch_ctrl: directed vector table, randomized run against
// a behavioural model, and (with BRANCH_STATS_EN) counter checks.
module tb_pc_branch_ctrl;

    logic        clock = 1'b0;
    logic        reset_n, stall, br_valid, ne, lt, status_nz;
    logic [2:0]  br_op;
    logic [11:0] ex_pc;
    logic [31:0] imm, rs_val;
    logic [11:0] pc, link_pc;
    logic        flush, link_we;
`ifdef BRANCH_STATS_EN
    logic [15:0] br_cnt, taken_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pc_branch_ctrl #(.PC_W(12), .RESET_PC(12'h010), .FLUSH_DEPTH(2)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .stall     (stall),
        .br_valid  (br_valid),
        .br_op     (br_op),
        .ex_pc     (ex_pc),
        .imm       (imm),
        .rs_val    (rs_val),
        .ne        (ne),
        .lt        (lt),
        .status_nz (status_nz),
        .pc        (pc),
        .flush     (flush),
        .link_we   (link_we),
        .link_pc   (link_pc)
`ifdef BRANCH_STATS_EN
        ,
        .br_cnt    (br_cnt),
        .taken_cnt (taken_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rn, st, bv;
        logic [2:0]  op;
        logic [11:0] xpc;
        logic [31:0] im, rs;
        logic        fne, flt, fsnz;
        logic [11:0] e_pc;
        logic        e_fl, e_lwe;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic rn, logic st, logic bv, logic [2:0] op,
                                logic [11:0] xpc, logic [31:0] im, logic [31:0] rs,
                                logic fne, logic flt, logic fsnz,
                                logic [11:0] e_pc, logic e_fl, logic e_lwe);
        vec_t v;
        v.rn = rn; v.st = st; v.bv = bv; v.op = op; v.xpc = xpc; v.im = im;
        v.rs = rs; v.fne = fne; v.flt = flt; v.fsnz = fsnz;
        v.e_pc = e_pc; v.e_fl = e_fl; v.e_lwe = e_lwe;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rn, input logic st, input logic bv, input logic [2:0] op,
                         input logic [11:0] xpc, input logic [31:0] im, input logic [31:0] rs,
                         input logic fne, input logic flt, input logic fsnz);
        reset_n = rn; stall = st; br_valid = bv; br_op = op; ex_pc = xpc;
        imm = im; rs_val = rs; ne = fne; lt = flt; status_nz = fsnz;
    endtask

    // Behavioural reference: pc value and number of flush cycles still owed.
    int m_pc, m_left;

    function automatic bit m_taken(logic [2:0] op, logic fne, logic flt, logic fsnz);
        case (op)
            3'd1: return fne;
            3'd2: return flt;
            3'd3, 3'd4, 3'd5: return 1'b1;
            3'd6: return fsnz;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int m_target(logic [2:0] op, logic [11:0] xpc, logic [31:0] im, logic [31:0] rs);
        if (op == 3'd1 || op == 3'd2) return (int'(xpc) + 1 + int'(im & 32'hFFF)) % 4096;
        if (op == 3'd5) return int'(rs & 32'hFFF);
        return int'(im & 32'hFFF);
    endfunction

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset, reset overriding stall and a jump, release
        vq.push_back(mk(0,0,0,0, 12'h000, 32'h0,        32'h0, 0,0,0, 12'h010,0,0));
        vq.push_back(mk(0,1,1,3, 12'h000, 32'h555,      32'h0, 0,0,0, 12'h010,0,0));
        vq.push_back(mk(1,0,0,0, 12'h000, 32'h0,        32'h0, 0,0,0, 12'h011,0,0));
        vq.push_back(mk(1,0,0,0, 12'h000, 32'h0,        32'h0, 0,0,0, 12'h012,0,0));
        // bne taken, negative offset, two flush cycles
        vq.push_back(mk(1,0,1,1, 12'h020, 32'hFFFFFFFC, 32'h0, 1,0,0, 12'h01D,1,0));
        vq.push_back(mk(1,0,0,0, 12'h000, 32'h0,        32'h0, 0,0,0, 12'h01E,1,0));
        vq.push_back(mk(1,0,0,0, 12'h000, 32'h0,        32'h0, 0,0,0, 12'h01F,0,0));
        vq.push_back(mk(1,0,0,0, 12'h000, 32'h0,        32'h0, 0,0,0, 12'h020,0,0));
        // jal with link_pc wrap
        vq.push_back(mk(1,0,1,4, 12'hFFF, 32'h100,      32'h0, 0,0,0, 12'h100,1,1));
        // jr in first flush cycle ignored, then two stalls stretch the flush
        vq.push_back(mk(1,0,1,5, 12'h000, 32'h0,      32'h777, 0,0,0, 12'h101,1,0));
        vq.push_back(mk(1,1,1,4, 12'h050, 32'h0,        32'h0, 0,0,0, 12'h101,1,0));
        vq.push_back(mk(1,1,0,0, 12'h000, 32'h0,        32'h0, 0,0,0, 12'h101,1,0));
        vq.push_back(mk(1,0,0,0, 12'h000, 32'h0,        32'h0, 0,0,0, 12'h102,0,0));
        // jump near the top, then pc wraps FFF -> 000
        vq.push_back(mk(1,0,1,3, 12'h000, 32'hFFC,      32'h0, 0,0,0, 12'hFFC,1,0));
        vq.push_back(mk(1,0,0,0, 12'h000, 32'h0,        32'h0, 0,0,0, 12'hFFD,1,0));
        vq.push_back(mk(1,0,0,0, 12'h000, 32'h0,        32'h0, 0,0,0, 12'hFFE,0,0));
        vq.push_back(mk(1,0,0,0, 12'h000, 32'h0,        32'h0, 0,0,0, 12'hFFF,0,0));
        vq.push_back(mk(1,0,0,0, 12'h000, 32'h0,        32'h0, 0,0,0, 12'h000,0,0));
        // not-taken blt and bex
        vq.push_back(mk(1,0,1,2, 12'h005, 32'h10,       32'h0, 1,0,1, 12'h001,0,0));
        vq.push_back(mk(1,0,1,6, 12'h005, 32'h300,      32'h0, 1,1,0, 12'h002,0,0));
        // taken bex, upper imm bits ignored
        vq.push_back(mk(1,0,1,6, 12'h000, 32'hFFFFF0AB, 32'h0, 0,0,1, 12'h0AB,1,0));
        vq.push_back(mk(1,0,0,0, 12'h000, 32'h0,        32'h0, 0,0,0, 12'h0AC,1,0));
        vq.push_back(mk(1,0,0,0, 12'h000, 32'h0,        32'h0, 0,0,0, 12'h0AD,0,0));
        // jr, then reset during flush aborts it
        vq.push_back(mk(1,0,1,5, 12'h000, 32'h0, 32'h12345678, 0,0,0, 12'h678,1,0));
        vq.push_back(mk(0,0,0,0, 12'h000, 32'h0,        32'h0, 0,0,0, 12'h010,0,0));
        vq.push_back(mk(1,0,0,0, 12'h000, 32'h0,        32'h0, 0,0,0, 12'h011,0,0));
        // taken blt, stall in first flush cycle suppresses jal link
        vq.push_back(mk(1,0,1,2, 12'h7F0, 32'h20,       32'h0, 0,1,0, 12'h811,1,0));
        vq.push_back(mk(1,1,1,4, 12'h123, 32'h0,        32'h0, 0,0,0, 12'h811,1,0));
        vq.push_back(mk(1,0,0,0, 12'h000, 32'h0,        32'h0, 0,0,0, 12'h812,1,0));
        vq.push_back(mk(1,0,0,0, 12'h000, 32'h0,        32'h0, 0,0,0, 12'h813,0,0));
        // reserved op, not-taken bne, jump without br_valid, stalled jump
        vq.push_back(mk(1,0,1,7, 12'h000, 32'h400,      32'h0, 1,1,1, 12'h814,0,0));
        vq.push_back(mk(1,0,1,1, 12'h000, 32'h400,      32'h0, 0,1,1, 12'h815,0,0));
        vq.push_back(mk(1,0,0,3, 12'h000, 32'h222,      32'h0, 0,0,0, 12'h816,0,0));
        vq.push_back(mk(1,1,1,3, 12'h000, 32'h222,      32'h0, 0,0,0, 12'h816,0,0));
        vq.push_back(mk(1,0,1,4, 12'h0AA, 32'h0,        32'h0, 0,0,0, 12'h000,1,1));

        foreach (vq[i]) begin
            @(negedge clock);
            drive(vq[i].rn, vq[i].st, vq[i].bv, vq[i].op, vq[i].xpc, vq[i].im,
                  vq[i].rs, vq[i].fne, vq[i].flt, vq[i].fsnz);
            #1;
            chk($sformatf("vec%0d link_we", i), 32'(link_we), 32'(vq[i].e_lwe));
            chk($sformatf("vec%0d link_pc", i), 32'(link_pc), (32'(vq[i].xpc) + 1) & 32'hFFF);
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d pc", i), 32'(pc), 32'(vq[i].e_pc));
            chk($sformatf("vec%0d flush", i), 32'(flush), 32'(vq[i].e_fl));
        end

        // Randomized run against the behavioural model
        m_pc = 0;
        m_left = 0;
        for (int n = 0; n < 2000; n++) begin
            logic        rn, st, bv, fne, flt, fsnz;
            logic [2:0]  op;
            logic [11:0] xpc;
            logic [31:0] im, rs;
            bit          exp_lwe;
            @(negedge clock);
            rn   = (n == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
            st   = ($urandom_range(0, 3) == 0);
            bv   = ($urandom_range(0, 2) != 0);
            op   = 3'($urandom_range(0, 7));
            xpc  = 12'($urandom);
            im   = ($urandom_range(0, 1) == 0) ? 32'($signed($urandom_range(0, 63)) - 32) : $urandom;
            rs   = $urandom;
            fne  = 1'($urandom);
            flt  = 1'($urandom);
            fsnz = 1'($urandom);
            drive(rn, st, bv, op, xpc, im, rs, fne, flt, fsnz);
            #1;
            exp_lwe = bv && (op == 3'd4) && !st && (m_left == 0);
            chk("rand link_we", 32'(link_we), 32'(exp_lwe));
            chk("rand link_pc", 32'(link_pc), (32'(xpc) + 1) % 4096);
            if (!rn) begin
                m_pc = 12'h010;
                m_left = 0;
            end else if (!st) begin
                if (m_left > 0) begin
                    m_left--;
                    m_pc = (m_pc + 1) % 4096;
                end else if (bv && m_taken(op, fne, flt, fsnz)) begin
                    m_pc = m_target(op, xpc, im, rs);
                    m_left = 2;
                end else begin
                    m_pc = (m_pc + 1) % 4096;
                end
            end
            @(posedge clock);
            #1;
            chk("rand pc", 32'(pc), 32'(m_pc));
            chk("rand flush", 32'(flush), 32'(m_left > 0));
        end

`ifdef BRANCH_STATS_EN
        // Three accepted bne, two taken
        @(negedge clock); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock); drive(1, 0, 1, 1, 12'h100, 32'h4, 0, 0, 0, 0);
        @(negedge clock); drive(1, 0, 1, 1, 12'h100, 32'h4, 0, 1, 0, 0);
        @(negedge clock); drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock); drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock); drive(1, 0, 1, 1, 12'h200, 32'h4, 0, 1, 0, 0);
        @(negedge clock); drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock); drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("stats br_cnt", 32'(br_cnt), 32'd3);
        chk("stats taken_cnt", 32'(taken_cnt), 32'd2);
        // Drive br_cnt to saturation with not-taken bne and confirm it holds
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        drive(1, 0, 1, 1, 12'h000, 32'h4, 0, 0, 0, 0);
        for (int k = 0; k < 65540; k++) @(negedge clock);
        chk("stats br_cnt sat", 32'(br_cnt), 32'hFFFF);
        chk("stats taken_cnt idle", 32'(taken_cnt), 32'h0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
